// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU definitions: unit-select codes, issue-controller state encoding
// and the 2-bit sub-op constants understood by every execution unit.
package alu_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        UNIT_ARITH = 2'b00,
        UNIT_LOGIC = 2'b01,
        UNIT_CMP   = 2'b10,
        UNIT_SHIFT = 2'b11
    } alu_unit_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    localparam logic [1:0] ARITH_ADD = 2'b00;
    localparam logic [1:0] ARITH_SUB = 2'b01;
    localparam logic [1:0] ARITH_INC = 2'b10;
    localparam logic [1:0] ARITH_DEC = 2'b11;

    localparam logic [1:0] LOGIC_AND = 2'b00;
    localparam logic [1:0] LOGIC_OR  = 2'b01;
    localparam logic [1:0] LOGIC_XOR = 2'b10;
    localparam logic [1:0] LOGIC_NOT = 2'b11;

    localparam logic [1:0] CMP_EQ  = 2'b00;
    localparam logic [1:0] CMP_LT  = 2'b01;
    localparam logic [1:0] CMP_GT  = 2'b10;
    localparam logic [1:0] CMP_NE  = 2'b11;

    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;
    localparam logic [1:0] SHIFT_ROL = 2'b11;

    // Enable vector bit order: {SHIFT, CMP, LOGIC, ARITH}.
    function automatic logic [3:0] unit_onehot(input alu_unit_e unit);
        return 4'b0001 << unit;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues one command at a time to the selected ALU unit, waits for its
// result flag (with timeout) and holds the result until the consumer takes it.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int OPERAND_WIDTH = 16,
    parameter int OUT_WIDTH     = 16,
    parameter int TIMEOUT_CYC   = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic [OPERAND_WIDTH-1:0] REQ_A,
    input  logic [OPERAND_WIDTH-1:0] REQ_B,
    input  logic [3:0]               REQ_FUN,
    output logic [OPERAND_WIDTH-1:0] A_OUT,
    output logic [OPERAND_WIDTH-1:0] B_OUT,
    output logic [1:0]               ALU_FUN_OUT,
    output logic                     ARITH_EN,
    output logic                     LOGIC_EN,
    output logic                     CMP_EN,
    output logic                     SHIFT_EN,
    input  logic                     ARITH_FLAG,
    input  logic                     LOGIC_FLAG,
    input  logic                     CMP_FLAG,
    input  logic                     SHIFT_FLAG,
    input  logic [OUT_WIDTH-1:0]     ARITH_OUT,
    input  logic [OUT_WIDTH-1:0]     LOGIC_OUT,
    input  logic [OUT_WIDTH-1:0]     CMP_OUT,
    input  logic [OUT_WIDTH-1:0]     SHIFT_OUT,
    output logic                     RES_VALID,
    input  logic                     RES_READY,
    output logic [OUT_WIDTH-1:0]     RES_DATA,
    output logic                     RES_ERR,
    output alu_state_e               STATE_DBG
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid is never dropped by the controller before ready is seen.

    localparam int CNT_W = 8;

    alu_state_e           state;
    alu_unit_e            unit_sel;
    logic [3:0]           en_q;
    logic [CNT_W-1:0]     cnt;
    logic                 req_ready_q;
    logic                 res_valid_q;
    logic [OUT_WIDTH-1:0] res_data_q;
    logic                 res_err_q;
    logic                 sel_flag;
    logic [OUT_WIDTH-1:0] sel_out;
    logic                 flag_ok;

    always_comb begin
        sel_flag = 1'b0;
        sel_out  = '0;
        case (unit_sel)
            UNIT_ARITH: begin sel_flag = ARITH_FLAG; sel_out = ARITH_OUT; end
            UNIT_LOGIC: begin sel_flag = LOGIC_FLAG; sel_out = LOGIC_OUT; end
            UNIT_CMP:   begin sel_flag = CMP_FLAG;   sel_out = CMP_OUT;   end
            UNIT_SHIFT: begin sel_flag = SHIFT_FLAG; sel_out = SHIFT_OUT; end
            default:    begin sel_flag = 1'b0;       sel_out = '0;        end
        endcase
    end

    // The first BUSY cycle (cnt == 1) may still see a flag left over from the
    // unit's previous job, so only later cycles qualify.
    assign flag_ok = sel_flag && (cnt != CNT_W'(1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            unit_sel    <= UNIT_ARITH;
            en_q        <= '0;
            cnt         <= '0;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            A_OUT       <= '0;
            B_OUT       <= '0;
            ALU_FUN_OUT <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (REQ_VALID && req_ready_q) begin
                        A_OUT       <= REQ_A;
                        B_OUT       <= REQ_B;
                        ALU_FUN_OUT <= REQ_FUN[1:0];
                        unit_sel    <= alu_unit_e'(REQ_FUN[3:2]);
                        en_q        <= unit_onehot(alu_unit_e'(REQ_FUN[3:2]));
                        cnt         <= CNT_W'(1);
                        req_ready_q <= 1'b0;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A genuine flag wins over a timeout on the same edge.
                    if (flag_ok) begin
                        res_data_q  <= sel_out;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        en_q        <= '0;
                        cnt         <= '0;
                        state       <= ST_DONE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        en_q        <= '0;
                        cnt         <= '0;
                        state       <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (RES_READY) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    en_q        <= '0;
                    req_ready_q <= 1'b1;
                    res_valid_q <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign REQ_READY = req_ready_q;
    assign RES_VALID = res_valid_q;
    assign RES_DATA  = res_data_q;
    assign RES_ERR   = res_err_q;
    assign ARITH_EN  = en_q[UNIT_ARITH];
    assign LOGIC_EN  = en_q[UNIT_LOGIC];
    assign CMP_EN    = en_q[UNIT_CMP];
    assign SHIFT_EN  = en_q[UNIT_SHIFT];
    assign STATE_DBG = state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with simple behavioural unit models whose
// flags can be auto-generated (one cycle after EN) or forced per unit.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST;
    logic         REQ_VALID;
    logic         REQ_READY;
    logic [W-1:0] REQ_A;
    logic [W-1:0] REQ_B;
    logic [3:0]   REQ_FUN;
    logic [W-1:0] A_OUT;
    logic [W-1:0] B_OUT;
    logic [1:0]   ALU_FUN_OUT;
    logic         ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN;
    logic         ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG;
    logic [W-1:0] ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT;
    logic         RES_VALID;
    logic         RES_READY;
    logic [W-1:0] RES_DATA;
    logic         RES_ERR;
    alu_state_e   STATE_DBG;

    int n_checks = 0;
    int n_errors = 0;

    logic       auto_on;
    logic [3:0] ovr_flag;
    logic [3:0] auto_flag_q = 4'b0000;
    logic [3:0] en_vec;

    always #5 CLK = ~CLK;

    alu_issue_ctrl #(.OPERAND_WIDTH(W), .OUT_WIDTH(W), .TIMEOUT_CYC(8)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_FUN(REQ_FUN),
        .A_OUT(A_OUT), .B_OUT(B_OUT), .ALU_FUN_OUT(ALU_FUN_OUT),
        .ARITH_EN(ARITH_EN), .LOGIC_EN(LOGIC_EN), .CMP_EN(CMP_EN), .SHIFT_EN(SHIFT_EN),
        .ARITH_FLAG(ARITH_FLAG), .LOGIC_FLAG(LOGIC_FLAG), .CMP_FLAG(CMP_FLAG), .SHIFT_FLAG(SHIFT_FLAG),
        .ARITH_OUT(ARITH_OUT), .LOGIC_OUT(LOGIC_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .RES_ERR(RES_ERR),
        .STATE_DBG(STATE_DBG)
    );

    assign en_vec = {SHIFT_EN, CMP_EN, LOGIC_EN, ARITH_EN};

    // Unit models: a flag follows EN by one cycle when auto_on, plus forced flags.
    always @(posedge CLK) auto_flag_q <= en_vec & {4{auto_on}};
    assign ARITH_FLAG = auto_flag_q[0] | ovr_flag[0];
    assign LOGIC_FLAG = auto_flag_q[1] | ovr_flag[1];
    assign CMP_FLAG   = auto_flag_q[2] | ovr_flag[2];
    assign SHIFT_FLAG = auto_flag_q[3] | ovr_flag[3];

    assign ARITH_OUT = (ALU_FUN_OUT == ARITH_SUB) ? A_OUT - B_OUT : A_OUT + B_OUT;
    assign LOGIC_OUT = (ALU_FUN_OUT == LOGIC_AND) ? (A_OUT & B_OUT) :
                       (ALU_FUN_OUT == LOGIC_OR)  ? (A_OUT | B_OUT) :
                       (ALU_FUN_OUT == LOGIC_XOR) ? (A_OUT ^ B_OUT) : ~A_OUT;
    assign CMP_OUT   = 16'hC0DE;
    assign SHIFT_OUT = A_OUT << B_OUT[3:0];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fun);
        REQ_A     = a;
        REQ_B     = b;
        REQ_FUN   = fun;
        REQ_VALID = 1'b1;
        step();
        REQ_VALID = 1'b0;
    endtask

    initial begin
        RST = 1'b1; REQ_VALID = 1'b0; REQ_A = '0; REQ_B = '0; REQ_FUN = '0;
        RES_READY = 1'b0; auto_on = 1'b1; ovr_flag = 4'b0000;
        step(); step();

        chk("rst_req_ready", REQ_READY, 1);
        chk("rst_res_valid", RES_VALID, 0);
        chk("rst_res_data", RES_DATA, 0);
        chk("rst_res_err", RES_ERR, 0);
        chk("rst_a_out", A_OUT, 0);
        chk("rst_b_out", B_OUT, 0);
        chk("rst_fun_out", ALU_FUN_OUT, 0);
        chk("rst_en", en_vec, 4'b0000);
        chk("rst_state", STATE_DBG, ST_IDLE);
        RST = 1'b0;
        step();

        // Logic AND, latency and backpressure
        issue(16'hF0F0, 16'hFF00, 4'b0100);
        chk("and_c1_en", en_vec, 4'b0010);
        chk("and_c1_req_ready", REQ_READY, 0);
        chk("and_c1_a", A_OUT, 16'hF0F0);
        chk("and_c1_b", B_OUT, 16'hFF00);
        chk("and_c1_fun", ALU_FUN_OUT, 2'b00);
        chk("and_c1_state", STATE_DBG, ST_BUSY);
        chk("and_c1_valid", RES_VALID, 0);
        step();
        chk("and_c2_en", en_vec, 4'b0010);
        chk("and_c2_valid", RES_VALID, 0);
        step();
        chk("and_c3_valid", RES_VALID, 1);
        chk("and_c3_data", RES_DATA, 16'hF000);
        chk("and_c3_err", RES_ERR, 0);
        chk("and_c3_en", en_vec, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", RES_VALID, 1);
            chk("bp_data", RES_DATA, 16'hF000);
            chk("bp_err", RES_ERR, 0);
            chk("bp_req_ready", REQ_READY, 0);
            chk("bp_en", en_vec, 4'b0000);
        end
        RES_READY = 1'b1;
        step();
        chk("and_drain_valid", RES_VALID, 0);
        chk("and_drain_req_ready", REQ_READY, 1);
        RES_READY = 1'b0;

        // Timeout with no flag: 8 BUSY cycles, then error result
        auto_on = 1'b0;
        issue(16'h1234, 16'h0001, 4'b0000);
        for (int i = 1; i <= 8; i++) begin
            chk("to_busy_en", en_vec, 4'b0001);
            chk("to_busy_valid", RES_VALID, 0);
            step();
        end
        chk("to_valid", RES_VALID, 1);
        chk("to_err", RES_ERR, 1);
        chk("to_data", RES_DATA, 0);
        chk("to_en", en_vec, 4'b0000);
        chk("to_a_stable", A_OUT, 16'h1234);
        RES_READY = 1'b1;
        step();
        RES_READY = 1'b0;

        // Flag on the same edge as the timeout wins
        issue(16'h0003, 16'h0004, 4'b0000);
        for (int i = 1; i <= 7; i++) step();
        chk("edge_c8_valid", RES_VALID, 0);
        ovr_flag = 4'b0001;
        step();
        ovr_flag = 4'b0000;
        chk("edge_valid", RES_VALID, 1);
        chk("edge_err", RES_ERR, 0);
        chk("edge_data", RES_DATA, 16'h0007);
        RES_READY = 1'b1;
        step();
        RES_READY = 1'b0;

        // Stale selected flag on first BUSY cycle and foreign CMP flag ignored
        ovr_flag = 4'b0101;
        issue(16'h0010, 16'h0003, 4'b0001);
        chk("stale_c1_en", en_vec, 4'b0001);
        step();
        chk("stale_c2_valid", RES_VALID, 0);
        ovr_flag = 4'b0100;
        step();
        chk("foreign_c3_valid", RES_VALID, 0);
        step();
        chk("foreign_c4_valid", RES_VALID, 0);
        ovr_flag = 4'b0001;
        step();
        ovr_flag = 4'b0000;
        chk("genuine_valid", RES_VALID, 1);
        chk("genuine_data", RES_DATA, 16'h000D);
        chk("genuine_err", RES_ERR, 0);
        RES_READY = 1'b1;
        step();

        // Back-to-back commands with REQ_VALID held high
        auto_on = 1'b1;
        REQ_A = 16'h00F0; REQ_B = 16'h0F00; REQ_FUN = 4'b0101; REQ_VALID = 1'b1;
        step();
        chk("b2b_c1_en", en_vec, 4'b0010);
        REQ_A = 16'h0001; REQ_B = 16'h0004; REQ_FUN = 4'b1100;
        step();
        chk("b2b_c2_en", en_vec, 4'b0010);
        step();
        chk("b2b_c3_valid", RES_VALID, 1);
        chk("b2b_c3_data", RES_DATA, 16'h0FF0);
        chk("b2b_c3_en", en_vec, 4'b0000);
        step();
        chk("b2b_gap_valid", RES_VALID, 0);
        chk("b2b_gap_req_ready", REQ_READY, 1);
        chk("b2b_gap_en", en_vec, 4'b0000);
        step();
        REQ_VALID = 1'b0;
        chk("b2b_c5_en", en_vec, 4'b1000);
        chk("b2b_c5_a", A_OUT, 16'h0001);
        chk("b2b_c5_req_ready", REQ_READY, 0);
        step();
        step();
        chk("b2b_c7_valid", RES_VALID, 1);
        chk("b2b_c7_data", RES_DATA, 16'h0010);
        step();

        // Reset in the second BUSY cycle discards the command
        issue(16'h0005, 16'h0006, 4'b0000);
        step();
        chk("mid_c2_en", en_vec, 4'b0001);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("mid_en", en_vec, 4'b0000);
        chk("mid_valid", RES_VALID, 0);
        chk("mid_req_ready", REQ_READY, 1);
        chk("mid_a", A_OUT, 0);
        chk("mid_state", STATE_DBG, ST_IDLE);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_result", RES_VALID, 0);
            chk("mid_idle_en", en_vec, 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameters: OPERAND_WIDTH, 16, width of A/B operands; OUT_WIDTH, 16, width of unit results and RES_DATA; TIMEOUT_CYC, 8, maximum BUSY cycles awaiting a unit flag (legal range 2..255).
REQ-002 SHALL have ports, in this order:
- CLK, input, 1, single clock; all state changes on rising edge.
- RST, input, 1, synchronous, active-high reset.
- REQ_VALID, input, 1, command request valid.
- REQ_READY, output, 1, controller can accept a command.
- REQ_A, input, OPERAND_WIDTH, operand A.
- REQ_B, input, OPERAND_WIDTH, operand B.
- REQ_FUN, input, 4, [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] sub-op.
- A_OUT, output, OPERAND_WIDTH, registered operand A to units.
- B_OUT, output, OPERAND_WIDTH, registered operand B to units.
- ALU_FUN_OUT, output, 2, registered sub-op to units.
- ARITH_EN / LOGIC_EN / CMP_EN / SHIFT_EN, output, 1 each, unit enables.
- ARITH_FLAG / LOGIC_FLAG / CMP_FLAG / SHIFT_FLAG, input, 1 each, unit result-valid flags.
- ARITH_OUT / LOGIC_OUT / CMP_OUT / SHIFT_OUT, input, OUT_WIDTH each, unit results.
- RES_VALID, output, 1, result available.
- RES_READY, input, 1, consumer accepts result.
- RES_DATA, output, OUT_WIDTH, captured result.
- RES_ERR, output, 1, result is a timeout error.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-004 REQ_READY SHALL be 1 only in IDLE; a request is accepted on a rising edge where REQ_VALID and REQ_READY are both 1.
REQ-005 On accept, the FSM SHALL move to BUSY and register REQ_A, REQ_B, REQ_FUN[1:0] into A_OUT, B_OUT, ALU_FUN_OUT, and REQ_FUN[3:2] into an internal unit-select register.
REQ-006 In BUSY, exactly the selected unit's EN SHALL be 1; all other ENs SHALL be 0. All ENs SHALL be 0 in IDLE and DONE.
REQ-007 A_OUT, B_OUT and ALU_FUN_OUT SHALL stay stable from accept until the next accept.
REQ-008 The selected unit's FLAG SHALL be ignored on the first BUSY cycle (stale-flag guard); from the second BUSY cycle on, FLAG=1 SHALL capture the selected unit's OUT into RES_DATA, clear RES_ERR, and move to DONE.
REQ-009 A BUSY cycle counter SHALL start at 1 on BUSY entry. If it reaches TIMEOUT_CYC with no qualifying flag, the FSM SHALL move to DONE with RES_DATA=0 and RES_ERR=1.
REQ-010 A flag that arrives on the same edge as the timeout SHALL take priority: the result is captured and RES_ERR=0.
REQ-011 Flags from non-selected units SHALL be ignored in all states.
REQ-012 RES_VALID SHALL be 1 exactly in DONE. RES_DATA and RES_ERR SHALL hold while RES_VALID=1 and RES_READY=0.
REQ-013 DONE with RES_READY=1 SHALL move to IDLE on that edge. The next request can be accepted one cycle later, so there is at least one enable-low cycle between commands.
REQ-014 Latency with a unit that flags one cycle after EN: accept on edge 0, EN high in cycle 1, flag sampled at edge 2, RES_VALID=1 in cycle 3.

Reset
REQ-015 RST=1 at a rising edge SHALL force IDLE, clear all EN outputs, and set REQ_READY=1 (after the edge), RES_VALID=0, RES_DATA=0, RES_ERR=0, A_OUT=0, B_OUT=0, ALU_FUN_OUT=0 and the counter to 0, regardless of state.
REQ-016 Reset asserted mid-operation (BUSY or DONE) SHALL discard the pending command and its result, and SHALL drop EN on that same edge.

Structure
REQ-017 A shared ALU package SHALL hold the unit-select codes (ARITH, LOGIC, CMP, SHIFT), the state encoding, and the 2-bit sub-op constants used by all units.
REQ-018 The module SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-019 Logic AND: REQ_A=16'hF0F0, REQ_B=16'hFF00, REQ_FUN=4'b0100, LOGIC unit model -> RES_VALID in cycle 3, RES_DATA=16'hF000, RES_ERR=0, only LOGIC_EN pulsed.
REQ-020 Backpressure: RES_READY held 0 for 5 cycles -> RES_VALID, RES_DATA and RES_ERR stable, REQ_READY=0 and ENs 0 throughout.
REQ-021 Timeout: unit model with FLAG tied to 0 and TIMEOUT_CYC=8 -> after 8 BUSY cycles, RES_VALID=1, RES_ERR=1, RES_DATA=0.
REQ-022 Stale and foreign flags: CMP_FLAG=1 during an ARITH op, and the selected flag high on the first BUSY cycle -> neither is captured; the correct result is captured on the later genuine flag.
REQ-023 Back-to-back: REQ_VALID held 1 with two queued commands and RES_READY=1 -> second accept 1 cycle after the first DONE, with an EN-low gap of at least 1 cycle.
REQ-024 Mid-op reset: RST=1 in the second BUSY cycle -> on the next cycle all ENs 0, RES_VALID=0, REQ_READY=1, and no result emitted.
